data_memory_sized: RTL and testbench

DATA_MEMORY_SIZED -- requirements
Module: data_memory_sized

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_lane_align.sv | 44 ++++
 rtl/data_memory_sized.sv | 148 ++++++++++++++
 tb/tb_data_memory_sized.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared size encodings, FSM state type and data width for the data memory.
package mem_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    // Any set address bit below the access size makes the access misaligned.
    function automatic logic misaligned(input logic [2:0] byte_off, input logic [1:0] size);
        return |(byte_off & ~(3'b111 << size));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane mask / store shift and load extraction with sign or zero extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]      byte_off,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rword,
    output logic [7:0]      byte_en,
    output logic [XLEN-1:0] wdata_lane,
    output logic [XLEN-1:0] rdata_ext
);

    logic [5:0]      bit_off;
    logic [XLEN-1:0] shifted;

    always_comb begin
        bit_off    = {byte_off, 3'b000};
        shifted    = rword >> bit_off;
        wdata_lane = wdata << bit_off;
        byte_en    = 8'h00;
        rdata_ext  = shifted;
        case (size)
            SZ_B: begin
                byte_en   = 8'h01 << byte_off;
                rdata_ext = {{56{~is_unsigned & shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                byte_en   = 8'h03 << byte_off;
                rdata_ext = {{48{~is_unsigned & shifted[15]}}, shifted[15:0]};
            end
            SZ_W: begin
                byte_en   = 8'h0F << byte_off;
                rdata_ext = {{32{~is_unsigned & shifted[31]}}, shifted[31:0]};
            end
            default: begin
                byte_en   = 8'hFF;
                rdata_ext = shifted;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressed 64-bit data memory with sized stores and extending loads.
// Define DATA_MEMORY_SIZED_STATS_EN to add load/store/error response counters.
module data_memory_sized #(
    parameter int DEPTH = 1024,
    parameter int XLEN  = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
`ifdef DATA_MEMORY_SIZED_STATS_EN
    output logic [31:0]     stat_loads,
    output logic [31:0]     stat_stores,
    output logic [31:0]     stat_errors,
`endif
    output logic            resp_err
);

    // state | meaning
    // IDLE  | ready for a request; stores and errors resolve on the accept edge
    // READ  | array word registered, extract load data
    // RESP  | hold response until resp_ready

    localparam int AW = $clog2(DEPTH);
    localparam logic [XLEN-1:0] LIMIT = XLEN'(DEPTH) << 3;

    logic [XLEN-1:0] mem [DEPTH] = '{0: XLEN'(10), 1: XLEN'(20), 2: XLEN'(30), default: '0};

    mem_pkg::mem_state_e state, state_nxt;

    logic            accept;
    logic            req_err;
    logic [AW-1:0]   widx;
    logic [2:0]      addr_lo_q;
    logic [1:0]      size_q;
    logic            unsigned_q;
    logic [XLEN-1:0] rd_word;
    logic [2:0]      lane_off;
    logic [1:0]      lane_size;
    logic [7:0]      byte_en;
    logic [XLEN-1:0] wdata_lane;
    logic [XLEN-1:0] lane_rdata;

    assign req_ready  = (state == mem_pkg::IDLE);
    assign resp_valid = (state == mem_pkg::RESP);
    assign accept     = req_valid && req_ready;
    assign req_err    = mem_pkg::misaligned(req_addr[2:0], req_size) || (req_addr >= LIMIT);
    assign widx       = req_addr[AW+2:3];

    // Stores align from the live request; loads extract from the captured fields.
    assign lane_off  = (state == mem_pkg::IDLE) ? req_addr[2:0] : addr_lo_q;
    assign lane_size = (state == mem_pkg::IDLE) ? req_size : size_q;

    mem_lane_align u_lane_align (
        .byte_off    (lane_off),
        .size        (lane_size),
        .is_unsigned (unsigned_q),
        .wdata       (req_wdata),
        .rword       (rd_word),
        .byte_en     (byte_en),
        .wdata_lane  (wdata_lane),
        .rdata_ext   (lane_rdata)
    );

    always_ff @(posedge clk) begin
        if (accept && !reset && req_we && !req_err) begin
            for (int b = 0; b < 8; b++) begin
                if (byte_en[b]) mem[widx][b*8 +: 8] <= wdata_lane[b*8 +: 8];
            end
        end
        if (accept) rd_word <= mem[widx];
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_lo_q  <= req_addr[2:0];
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= mem_pkg::IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            mem_pkg::IDLE: if (accept) state_nxt = (req_err || req_we) ? mem_pkg::RESP : mem_pkg::READ;
            mem_pkg::READ: state_nxt = mem_pkg::RESP;
            mem_pkg::RESP: if (resp_ready) state_nxt = mem_pkg::IDLE;
            default:       state_nxt = mem_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                mem_pkg::IDLE: if (accept) begin
                    resp_rdata <= '0;
                    resp_err   <= req_err;
                end
                mem_pkg::READ: begin
                    resp_rdata <= lane_rdata;
                    resp_err   <= 1'b0;
                end
                mem_pkg::RESP: if (resp_ready) begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef DATA_MEMORY_SIZED_STATS_EN
    logic we_q;

    always_ff @(posedge clk) begin
        if (accept) we_q <= req_we;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_errors <= '0;
        end else if (resp_valid && resp_ready) begin
            if (resp_err)  stat_errors <= stat_errors + 32'd1;
            else if (we_q) stat_stores <= stat_stores + 32'd1;
            else           stat_loads  <= stat_loads + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized: sized loads/stores, errors, backpressure, reset.
module tb_data_memory_sized;
    import mem_pkg::*;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
`ifdef DATA_MEMORY_SIZED_STATS_EN
    logic [31:0] stat_loads, stat_stores, stat_errors;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    data_memory_sized #(.DEPTH(DEPTH), .XLEN(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
`ifdef DATA_MEMORY_SIZED_STATS_EN
        .stat_loads   (stat_loads),
        .stat_stores  (stat_stores),
        .stat_errors  (stat_errors),
`endif
        .resp_err     (resp_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Issue one request, scramble the inputs after accept, return the response.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wd,
                          output logic [63:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 64'(n >= 20), 64'd0);
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_size = ~sz; req_unsigned = ~uns;
        req_addr = ~addr; req_wdata = ~wd;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        if (resp_ready) begin
            @(posedge clk); #1;
        end
    endtask

    logic [63:0] rd;
    logic        er;
    int          lat;
    int          acc;
    int          seen;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_rdata", resp_rdata, 64'd0);
        check("rst_err", 64'(resp_err), 64'd0);

        do_req(1'b0, SZ_D, 1'b0, 64'h8, 64'h0, rd, er, lat);
        check("ld8_data", rd, 64'd20);
        check("ld8_err", 64'(er), 64'd0);
        check("ld8_lat", 64'(lat), 64'd2);

        do_req(1'b1, SZ_B, 1'b0, 64'h13, 64'h1234_5678_9ABC_DEFF, rd, er, lat);
        check("stb_err", 64'(er), 64'd0);
        check("stb_lat", 64'(lat), 64'd1);
        check("stb_rdata", rd, 64'd0);
        do_req(1'b0, SZ_B, 1'b0, 64'h13, 64'h0, rd, er, lat);
        check("ldb_signed", rd, 64'hFFFF_FFFF_FFFF_FFFF);
        do_req(1'b0, SZ_B, 1'b1, 64'h13, 64'h0, rd, er, lat);
        check("ldb_unsigned", rd, 64'h0000_0000_0000_00FF);
        do_req(1'b0, SZ_D, 1'b0, 64'h10, 64'h0, rd, er, lat);
        check("ldd_word2", rd, 64'h0000_0000_FF00_001E);

        do_req(1'b1, SZ_H, 1'b0, 64'h3, 64'hFFFF, rd, er, lat);
        check("sth_mis_err", 64'(er), 64'd1);
        check("sth_mis_rdata", rd, 64'd0);
        do_req(1'b0, SZ_D, 1'b0, 64'h0, 64'h0, rd, er, lat);
        check("ld0_after_err", rd, 64'd10);

        do_req(1'b0, SZ_W, 1'b0, 64'(DEPTH * 8), 64'h0, rd, er, lat);
        check("ldw_oor_err", 64'(er), 64'd1);
        check("ldw_oor_rdata", rd, 64'd0);
        do_req(1'b0, SZ_W, 1'b0, 64'h2, 64'h0, rd, er, lat);
        check("ldw_mis_err", 64'(er), 64'd1);

        // Last word of the array: legal boundary.
        do_req(1'b1, SZ_D, 1'b0, 64'(DEPTH * 8 - 8), 64'h8000_0000_0000_0001, rd, er, lat);
        check("std_last_err", 64'(er), 64'd0);
        do_req(1'b0, SZ_W, 1'b0, 64'(DEPTH * 8 - 4), 64'h0, rd, er, lat);
        check("ldw_last_hi", rd, 64'hFFFF_FFFF_8000_0000);
        do_req(1'b0, SZ_H, 1'b1, 64'(DEPTH * 8 - 2), 64'h0, rd, er, lat);
        check("ldh_last_u", rd, 64'h0000_0000_0000_8000);
        do_req(1'b0, SZ_W, 1'b1, 64'(DEPTH * 8 - 8), 64'h0, rd, er, lat);
        check("ldw_last_lo", rd, 64'h0000_0000_0000_0001);

        do_req(1'b1, SZ_H, 1'b0, 64'h20, 64'hABCD_1234, rd, er, lat);
        do_req(1'b1, SZ_W, 1'b0, 64'h24, 64'hDEAD_BEEF, rd, er, lat);
        do_req(1'b0, SZ_D, 1'b0, 64'h20, 64'h0, rd, er, lat);
        check("ldd_lanes", rd, 64'hDEAD_BEEF_0000_1234);
        do_req(1'b0, SZ_H, 1'b0, 64'h26, 64'h0, rd, er, lat);
        check("ldh_signed", rd, 64'hFFFF_FFFF_FFFF_DEAD);
        do_req(1'b0, SZ_B, 1'b1, 64'h25, 64'h0, rd, er, lat);
        check("ldb_u_25", rd, 64'h0000_0000_0000_00BE);

        // Backpressure: response held, no acceptance while in RESP.
        resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = SZ_D; req_unsigned = 1'b0; req_addr = 64'h8;
        @(posedge clk); #1;
        req_valid = 1'b0;
        seen = 0;
        while (!resp_valid && seen < 10) begin
            @(posedge clk); #1;
            seen++;
        end
        check("bp_valid", 64'(resp_valid), 64'd1);
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_D; req_addr = 64'h0; req_wdata = 64'hBAD;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 64'(resp_valid), 64'd1);
            check("bp_hold_rdata", resp_rdata, 64'd20);
            check("bp_hold_ready", 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", 64'(resp_valid), 64'd0);
        do_req(1'b0, SZ_D, 1'b0, 64'h0, 64'h0, rd, er, lat);
        check("bp_no_store", rd, 64'd10);

        // Throughput with resp_ready tied high.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_D; req_addr = 64'h40; req_wdata = 64'h1;
        acc = req_ready ? 1 : 0;
        repeat (7) begin
            @(negedge clk);
            if (req_valid && req_ready) acc++;
        end
        req_valid = 1'b0;
        check("tput_store", 64'(acc), 64'd4);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = SZ_D; req_addr = 64'h8;
        acc = req_ready ? 1 : 0;
        repeat (8) begin
            @(negedge clk);
            if (req_valid && req_ready) acc++;
        end
        req_valid = 1'b0;
        check("tput_load", 64'(acc), 64'd3);
        do_req(1'b0, SZ_D, 1'b0, 64'h40, 64'h0, rd, er, lat);
        check("tput_store_data", rd, 64'd1);

        // Reset while in READ drops the response.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = SZ_D; req_addr = 64'h8;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_read_valid", 64'(resp_valid), 64'd0);
        check("rst_read_ready", 64'(req_ready), 64'd1);
        check("rst_read_rdata", resp_rdata, 64'd0);
`ifdef DATA_MEMORY_SIZED_STATS_EN
        check("rst_stat_loads", 64'(stat_loads), 64'd0);
        check("rst_stat_stores", 64'(stat_stores), 64'd0);
        check("rst_stat_errors", 64'(stat_errors), 64'd0);
`endif
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        check("rst_read_no_resp", 64'(seen), 64'd0);

        // A store presented during reset is not written.
        @(negedge clk);
        reset = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_D; req_addr = 64'h30; req_wdata = 64'h55;
        @(posedge clk); #1;
        reset = 1'b0;
        req_valid = 1'b0;
        do_req(1'b0, SZ_D, 1'b0, 64'h30, 64'h0, rd, er, lat);
        check("rst_store_dropped", rd, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
